// File: rtl/param_ram.sv
// Parameterised RAM with dipswitch programming (debounced write button, optional
// auto-increment address) and a bus-driven run mode with a memory address register.
module param_ram #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int DEB_CYC = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              prog_mode,
    input  logic              auto_inc,
    input  logic [ADDR_W-1:0] dip_addr,
    input  logic [DATA_W-1:0] dip_data,
    input  logic              write_btn,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              load_mar_n,
    input  logic              ram_in,
    input  logic              ram_out_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] mar_q,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, WRITE, RELEASE} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt, next_cnt;
    logic              sync1, sync2;
    logic              fsm_we;
    logic              wr_en;
    logic [ADDR_W-1:0] dip_rev;
    logic [ADDR_W-1:0] prog_src;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= write_btn;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Switching to run mode aborts any button sequence without writing.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        fsm_we     = 1'b0;
        case (state)
            IDLE: begin
                if (sync2 && !prog_mode) begin
                    next_state = DEBOUNCE;
                    next_cnt   = '0;
                end
            end
            DEBOUNCE: begin
                if (prog_mode || !sync2) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = WRITE;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            WRITE: begin
                next_cnt = '0;
                if (prog_mode) begin
                    next_state = IDLE;
                end else begin
                    fsm_we     = 1'b1;
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (prog_mode) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (sync2) begin
                    next_cnt = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // The dipswitch bank is wired MSB-first, so its address bits arrive reversed.
    always_comb begin
        dip_rev = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            dip_rev[i] = dip_addr[ADDR_W-1-i];
        end
    end

    assign prog_src = auto_inc ? prog_addr : dip_rev;
    assign wr_en    = !clr && (prog_mode ? ram_in : fsm_we);
    assign wr_addr  = prog_mode ? mar_q : prog_src;
    assign wr_data  = prog_mode ? bus_in : dip_data;
    assign rd_addr  = prog_mode ? mar_q : prog_src;

    always_ff @(posedge clk) begin
        if (clr) begin
            mar_q     <= '0;
            prog_addr <= '0;
        end else begin
            if (prog_mode && !load_mar_n) begin
                mar_q <= bus_in[ADDR_W-1:0];
            end
            if (fsm_we && auto_inc) begin
                prog_addr <= prog_addr + ADDR_W'(1);
            end
        end
    end

    // Memory contents deliberately survive clr.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign bus_out   = ram_out_n ? '0 : mem[rd_addr];
    assign bus_oe    = ~ram_out_n;
    assign prog_busy = (state != IDLE);

endmodule

// File: tb/tb_param_ram.sv
// Directed testbench for param_ram: button programming, auto-increment, run-mode
// bus access, read-during-write ordering and clr behaviour.
module tb_param_ram;

    logic       clk = 1'b0;
    logic       clr;
    logic       prog_mode;
    logic       auto_inc;
    logic [3:0] dip_addr;
    logic [7:0] dip_data;
    logic       write_btn;
    logic [7:0] bus_in;
    logic       load_mar_n;
    logic       ram_in;
    logic       ram_out_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [3:0] mar_q;
    logic [3:0] prog_addr;
    logic       prog_busy;

    int checks = 0;
    int errors = 0;

    param_ram #(.DATA_W(8), .ADDR_W(4), .DEB_CYC(4)) dut (
        .clk(clk), .clr(clr), .prog_mode(prog_mode), .auto_inc(auto_inc),
        .dip_addr(dip_addr), .dip_data(dip_data), .write_btn(write_btn),
        .bus_in(bus_in), .load_mar_n(load_mar_n), .ram_in(ram_in),
        .ram_out_n(ram_out_n), .bus_out(bus_out), .bus_oe(bus_oe),
        .mar_q(mar_q), .prog_addr(prog_addr), .prog_busy(prog_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    // Hold the button for 'hold' cycles, release, then wait for the FSM to idle.
    task automatic press(input int hold, output logic ok);
        write_btn = 1'b1;
        repeat (hold) tick();
        write_btn = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!prog_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; prog_mode = 1'b0; auto_inc = 1'b0; dip_addr = '0;
        dip_data = '0; write_btn = 1'b0; bus_in = '0; load_mar_n = 1'b1;
        ram_in = 1'b0; ram_out_n = 1'b1;
        repeat (3) tick();
        clr = 1'b0;
        #1;
        checks++;
        if (mar_q !== 4'd0 || prog_addr !== 4'd0 || prog_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: mar_q=%0d prog_addr=%0d busy=%b, required 0 0 0", mar_q, prog_addr, prog_busy);
        end
        checks++;
        if (bus_out !== 8'h00 || bus_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_bus: bus_out=%h oe=%b, required 00 0", bus_out, bus_oe);
        end
    endtask

    task automatic test_single_write();
        int n;
        dip_addr = 4'b1000; dip_data = 8'hA5; ram_out_n = 1'b0;
        write_btn = 1'b1;
        repeat (10) tick();
        checks++;
        if (prog_busy !== 1'b1 || bus_out !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_write_held: busy=%b bus_out=%h, required 1 a5", prog_busy, bus_out);
        end
        write_btn = 1'b0;
        repeat (3) tick();
        checks++;
        if (prog_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_debounce: busy=%b, required 1", prog_busy);
        end
        n = 3;
        while (prog_busy && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 6) begin
            errors++;
            $display("[TB] FAIL release_length: idle after %0d cycles, required 6", n);
        end
        dip_data = 8'h00;
        repeat (5) tick();
        checks++;
        if (bus_out !== 8'hA5 || prog_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_write_once: bus_out=%h busy=%b, required a5 0", bus_out, prog_busy);
        end
    endtask

    task automatic test_short_press();
        dip_addr = 4'b1000; dip_data = 8'h3C; ram_out_n = 1'b0;
        write_btn = 1'b1;
        repeat (2) tick();
        write_btn = 1'b0;
        repeat (8) tick();
        checks++;
        if (bus_out !== 8'hA5 || prog_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_press: bus_out=%h busy=%b, required a5 0", bus_out, prog_busy);
        end
    endtask

    task automatic test_auto_inc();
        logic ok;
        logic [7:0] exp;
        auto_inc = 1'b1;
        for (int k = 0; k < 17; k++) begin
            dip_data = 8'(k);
            press(8, ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("[TB] FAIL auto_press_timeout: press %0d busy stuck, required idle", k);
            end
        end
        checks++;
        if (prog_addr !== 4'd1) begin
            errors++;
            $display("[TB] FAIL auto_wrap: prog_addr=%0d, required 1", prog_addr);
        end
        auto_inc = 1'b0; ram_out_n = 1'b0;
        for (int a = 0; a < 16; a++) begin
            dip_addr = rev4(4'(a));
            exp = (a == 0) ? 8'd16 : 8'(a);
            #1;
            checks++;
            if (bus_out !== exp) begin
                errors++;
                $display("[TB] FAIL auto_mem[%0d]: read %h, required %h", a, bus_out, exp);
            end
        end
    endtask

    task automatic test_run_mode();
        prog_mode = 1'b1; ram_out_n = 1'b1;
        bus_in = 8'h0E; load_mar_n = 1'b0;
        tick();
        load_mar_n = 1'b1; bus_in = 8'h3C; ram_in = 1'b1;
        tick();
        ram_in = 1'b0; ram_out_n = 1'b0;
        #1;
        checks++;
        if (mar_q !== 4'd14 || bus_out !== 8'h3C || bus_oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_read: mar=%0d bus_out=%h oe=%b, required 14 3c 1", mar_q, bus_out, bus_oe);
        end
        ram_out_n = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h00 || bus_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_disable: bus_out=%h oe=%b, required 00 0", bus_out, bus_oe);
        end
    endtask

    task automatic test_back_to_back();
        bus_in = 8'h02; load_mar_n = 1'b0;
        tick();
        bus_in = 8'h05; ram_in = 1'b1;
        tick();
        load_mar_n = 1'b1; ram_in = 1'b0;
        #1;
        checks++;
        if (mar_q !== 4'd5) begin
            errors++;
            $display("[TB] FAIL same_edge_mar: mar=%0d, required 5", mar_q);
        end
        bus_in = 8'h02; load_mar_n = 1'b0;
        tick();
        load_mar_n = 1'b1; ram_out_n = 1'b0;
        #1;
        checks++;
        if (bus_out !== 8'h05) begin
            errors++;
            $display("[TB] FAIL same_edge_data: mem[2]=%h, required 05", bus_out);
        end
    endtask

    task automatic test_read_during_write();
        bus_in = 8'h77; ram_in = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h05) begin
            errors++;
            $display("[TB] FAIL rdw_before: bus_out=%h, required 05", bus_out);
        end
        tick();
        ram_in = 1'b0;
        #1;
        checks++;
        if (bus_out !== 8'h77) begin
            errors++;
            $display("[TB] FAIL rdw_after: bus_out=%h, required 77", bus_out);
        end
    endtask

    task automatic test_clr_debounce();
        logic ok;
        prog_mode = 1'b0; auto_inc = 1'b0; ram_out_n = 1'b0;
        dip_addr = rev4(4'd3); dip_data = 8'h5A;
        press(8, ok);
        checks++;
        if (ok !== 1'b1 || bus_out !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL clr_setup: ok=%b mem[3]=%h, required 1 5a", ok, bus_out);
        end
        dip_data = 8'hFF;
        write_btn = 1'b1;
        repeat (3) tick();
        checks++;
        if (prog_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_in_debounce: busy=%b, required 1", prog_busy);
        end
        clr = 1'b1; write_btn = 1'b0;
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (mar_q !== 4'd0 || prog_addr !== 4'd0 || prog_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_state: mar=%0d prog_addr=%0d busy=%b, required 0 0 0", mar_q, prog_addr, prog_busy);
        end
        repeat (8) tick();
        checks++;
        if (bus_out !== 8'h5A || prog_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_no_write: mem[3]=%h busy=%b, required 5a 0", bus_out, prog_busy);
        end
        dip_addr = rev4(4'd1);
        #1;
        checks++;
        if (bus_out !== 8'h01) begin
            errors++;
            $display("[TB] FAIL clr_mem_kept: mem[1]=%h, required 01", bus_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_short_press();
        test_auto_inc();
        test_run_mode();
        test_back_to_back();
        test_read_during_write();
        test_clr_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set memory word and bus width.
REQ-002 Parameter ADDR_W, default 4, SHALL set MAR width; depth SHALL be 2^ADDR_W words.
REQ-003 Parameter DEB_CYC, default 4, SHALL set the push-button debounce length in clocks (min 1).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 clr  in  1  reset, synchronous and active-high.
REQ-006 prog_mode  in  1  0 = program mode (dipswitch source), 1 = run mode (bus source).
REQ-007 auto_inc  in  1  program mode only: 1 = address from internal program counter, 0 = from dip_addr.
REQ-008 dip_addr  in  ADDR_W  dipswitch address, MSB-first as wired; bit [ADDR_W-1] SHALL be address LSB.
REQ-009 dip_data  in  DATA_W  dipswitch data word.
REQ-010 write_btn  in  1  raw push button, asynchronous, active-high.
REQ-011 bus_in  in  DATA_W  bus data; MAR load uses bus_in[ADDR_W-1:0].
REQ-012 load_mar_n  in  1  active-low MAR load strobe.
REQ-013 ram_in  in  1  active-high run-mode write strobe.
REQ-014 ram_out_n  in  1  active-low bus output enable.
REQ-015 bus_out  out  DATA_W  read data; all zeros when not enabled.
REQ-016 bus_oe  out  1  high when bus_out is driving.
REQ-017 mar_q  out  ADDR_W  current MAR value.
REQ-018 prog_addr  out  ADDR_W  current auto-increment program counter.
REQ-019 prog_busy  out  1  high while the button FSM is outside IDLE.

Function
REQ-020 write_btn SHALL pass a 2-flop synchroniser; FSM sees the second stage only.
REQ-021 Button FSM states SHALL be IDLE, DEBOUNCE, WRITE, RELEASE.
REQ-022 IDLE -> DEBOUNCE when synced button = 1 and prog_mode = 0; debounce counter loads 0.
REQ-023 DEBOUNCE: counter increments each cycle while button = 1; button = 0 -> IDLE; counter reaches DEB_CYC-1 with button = 1 -> WRITE.
REQ-024 WRITE SHALL last exactly one cycle, issue one memory write, then -> RELEASE.
REQ-025 RELEASE -> IDLE only after button = 0 for DEB_CYC consecutive cycles; a held button SHALL never produce a second write.
REQ-026 prog_mode = 1 in any non-IDLE state SHALL force IDLE next cycle with no write.
REQ-027 Program-mode write address = prog_addr if auto_inc = 1, else bit-reversed dip_addr; data = dip_data.
REQ-028 With auto_inc = 1, prog_addr SHALL increment on the WRITE cycle, wrapping 2^ADDR_W-1 -> 0.
REQ-029 Run mode: MAR SHALL load bus_in[ADDR_W-1:0] when load_mar_n = 0.
REQ-030 Run mode: ram_in = 1 SHALL write bus_in to mem[mar_q] at that edge; write uses pre-edge MAR if load_mar_n also low.
REQ-031 ram_in SHALL be ignored in program mode; FSM writes SHALL be impossible in run mode.
REQ-032 Read address: run mode mar_q; program mode same source as REQ-027.
REQ-033 Read SHALL be combinational: bus_out = mem[read address] when ram_out_n = 0, else 0; bus_oe = ~ram_out_n.
REQ-034 Read and write same address same cycle: bus_out SHALL show old data until after the edge.

Reset
REQ-035 clr = 1 SHALL set mar_q = 0, prog_addr = 0, FSM = IDLE, debounce counter = 0, synchroniser flops = 0, prog_busy = 0.
REQ-036 clr SHALL NOT alter memory contents; clr mid-DEBOUNCE or WRITE SHALL suppress the pending write.
REQ-037 clr SHALL take priority over all other inputs in the same cycle.

Verification
REQ-038 prog_mode=0, auto_inc=0, dip_addr=4'b1000, dip_data=8'hA5, button high 10 cycles -> exactly one write, mem[1]=8'hA5, prog_busy high until release debounced.
REQ-039 Button high 2 cycles (DEB_CYC=4) -> no write, FSM back to IDLE.
REQ-040 auto_inc=1, 17 button presses, data = press index -> mem[0]=16, mem[1..15]=1..15, prog_addr=1 (wrap).
REQ-041 prog_mode=1, bus_in=8'h0E with load_mar_n=0, then bus_in=8'h3C with ram_in=1, then ram_out_n=0 -> mar_q=14, bus_out=8'h3C, bus_oe=1; ram_out_n=1 -> bus_out=0.
REQ-042 Same cycle load_mar_n=0 (bus_in=8'h05) and ram_in=1 with mar_q=2 -> mem[2] written with 8'h05, mar_q=5 after edge.
REQ-043 clr asserted during DEBOUNCE -> no write, all REQ-035 values, prior memory contents intact.
